// File: rtl/compression_pkg.sv
// Shared types and defaults for the compression engine initiator.
package compression_pkg;

  localparam int unsigned DEF_DATA_W = 80;
  localparam int unsigned DEF_CODE_W = 8;

  // Engine command encodings.
  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_INVALID    = 2'b11
  } cmd_t;

  // Engine response encodings; they mirror the command values.
  typedef enum logic [1:0] {
    RSP_IDLE   = 2'b00,
    RSP_COMP   = 2'b01,
    RSP_DECOMP = 2'b10,
    RSP_ERR    = 2'b11
  } rsp_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ENG_ERR = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_UNEXP   = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } init_state_t;

  // Command issued for a request op (0 = compress, 1 = decompress).
  function automatic cmd_t op_to_cmd(input logic op);
    return op ? CMD_DECOMPRESS : CMD_COMPRESS;
  endfunction

endpackage

// File: rtl/compression_initiator_if.sv
// Host-side request/response streams of the compression initiator.
interface compression_initiator_if #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned CODE_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_data;
  logic [CODE_W-1:0] req_code;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_data;
  logic [CODE_W-1:0] rsp_code;

  // Traffic source side.
  modport master (
    output req_valid, req_op, req_data, req_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_data, rsp_code
  );

  // Initiator side.
  modport slave (
    input  req_valid, req_op, req_data, req_code, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_data, rsp_code
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count up on inc, hold at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/compression_initiator.sv
// Host-side initiator: issues one compress/decompress command to the engine,
// waits for its response (with timeout) and returns a status-tagged result.
module compression_initiator
  import compression_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned CODE_W         = DEF_CODE_W,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  compression_initiator_if.slave  host,
  output logic [1:0]              eng_command,
  output logic [DATA_W-1:0]       eng_data_in,
  output logic [CODE_W-1:0]       eng_compressed_in,
  input  logic [CODE_W-1:0]       eng_compressed_out,
  input  logic [DATA_W-1:0]       eng_decompressed_out,
  input  logic [1:0]              eng_response,
  output logic [CNT_W-1:0]        ok_count,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

  init_state_t       state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [CODE_W-1:0] code_in_q, code_in_d;
  logic [7:0]        wait_q, wait_d;
  status_t           status_q, status_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CODE_W-1:0] rsp_code_q, rsp_code_d;

  rsp_t       eng_rsp;
  logic [7:0] wait_nxt;
  logic       timeout_hit;
  logic       rsp_fire;
  logic       ok_inc, err_inc;

  assign eng_rsp     = rsp_t'(eng_response);
  assign wait_nxt    = wait_q + 8'd1;
  assign timeout_hit = (eng_rsp == RSP_IDLE) && (wait_nxt == TimeoutLim);
  assign rsp_fire    = (state_q == StResp) && host.rsp_ready;
  assign ok_inc      = rsp_fire && (status_q == ST_OK);
  assign err_inc     = rsp_fire && (status_q != ST_OK);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (host.req_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if ((eng_rsp != RSP_IDLE) || timeout_hit) state_d = StResp;
      StResp:  if (host.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-state datapath updates: engine pins, wait counter and result capture.
  always_comb begin
    cmd_d      = cmd_q;
    op_d       = op_q;
    data_in_d  = data_in_q;
    code_in_d  = code_in_q;
    wait_d     = wait_q;
    status_d   = status_q;
    rsp_data_d = rsp_data_q;
    rsp_code_d = rsp_code_q;
    unique case (state_q)
      StIdle: begin
        if (host.req_valid) begin
          op_d      = host.req_op;
          data_in_d = host.req_data;
          code_in_d = host.req_code;
          cmd_d     = op_to_cmd(host.req_op);
        end
      end
      StIssue: begin
        // Command is only visible to the engine for this one cycle.
        cmd_d  = CMD_NOP;
        wait_d = '0;
      end
      StWait: begin
        unique case (eng_rsp)
          RSP_IDLE: begin
            wait_d = wait_nxt;
            if (timeout_hit) status_d = ST_TIMEOUT;
          end
          RSP_ERR: status_d = ST_ENG_ERR;
          default: begin
            if (eng_rsp == rsp_t'(op_to_cmd(op_q))) begin
              status_d = ST_OK;
              if (op_q) begin
                rsp_data_d = eng_decompressed_out;
                rsp_code_d = '0;
              end else begin
                rsp_data_d = '0;
                rsp_code_d = eng_compressed_out;
              end
            end else begin
              status_d = ST_UNEXP;
            end
          end
        endcase
      end
      StResp: ;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= CMD_NOP;
      op_q       <= 1'b0;
      data_in_q  <= '0;
      code_in_q  <= '0;
      wait_q     <= '0;
      status_q   <= ST_OK;
      rsp_data_q <= '0;
      rsp_code_q <= '0;
    end else begin
      cmd_q      <= cmd_d;
      op_q       <= op_d;
      data_in_q  <= data_in_d;
      code_in_q  <= code_in_d;
      wait_q     <= wait_d;
      status_q   <= status_d;
      rsp_data_q <= rsp_data_d;
      rsp_code_q <= rsp_code_d;
    end
  end

  assign host.req_ready  = (state_q == StIdle);
  assign host.rsp_valid  = (state_q == StResp);
  assign host.rsp_status = status_q;
  assign host.rsp_data   = rsp_data_q;
  assign host.rsp_code   = rsp_code_q;

  assign eng_command       = cmd_q;
  assign eng_data_in       = data_in_q;
  assign eng_compressed_in = code_in_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_inc),
    .clear (1'b0),
    .count (ok_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clear (1'b0),
    .count (err_count)
  );

endmodule

// File: tb/tb_compression_initiator.sv
// Bench for compression_initiator: behavioural engine stub, directed vector table,
// hand sequences (backpressure, mid-transaction reset, saturation) and random traffic.
module tb_compression_initiator;

  localparam int unsigned DW   = 80;
  localparam int unsigned CW   = 8;
  localparam int unsigned TO   = 8;
  localparam int unsigned CNTW = 4;
  localparam int          CMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  compression_initiator_if #(.DATA_W(DW), .CODE_W(CW)) bus ();

  logic [1:0]      eng_command;
  logic [DW-1:0]   eng_data_in;
  logic [CW-1:0]   eng_compressed_in;
  logic [CW-1:0]   eng_compressed_out = '0;
  logic [DW-1:0]   eng_decompressed_out = '0;
  logic [1:0]      eng_response = 2'b00;
  logic [CNTW-1:0] ok_count, err_count;

  compression_initiator #(
    .DATA_W         (DW),
    .CODE_W         (CW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNTW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .host                 (bus.slave),
    .eng_command          (eng_command),
    .eng_data_in          (eng_data_in),
    .eng_compressed_in    (eng_compressed_in),
    .eng_compressed_out   (eng_compressed_out),
    .eng_decompressed_out (eng_decompressed_out),
    .eng_response         (eng_response),
    .ok_count             (ok_count),
    .err_count            (err_count)
  );

  // ---------------- Engine stub ----------------
  // stub_mode 0: real dictionary engine, response eng_dly cycles late
  // stub_mode 1: never responds; stub_mode 2: always answers stub_rsp
  int         stub_mode = 0;
  logic [1:0] stub_rsp = 2'b00;
  int         eng_dly = 0;
  logic [DW-1:0] e_dict [256];
  int         e_n = 0;
  logic       p_pend = 1'b0;
  int         p_left = 0;
  logic [1:0] p_rsp;
  logic [DW-1:0] p_data;
  logic [CW-1:0] p_code;

  always @(posedge clk) begin : engine
    logic [1:0]    r;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    int            idx;
    eng_response <= 2'b00;
    if (eng_command == 2'b01 || eng_command == 2'b10) begin
      d = '0;
      c = '0;
      if (eng_command == 2'b01) begin
        idx = -1;
        for (int i = 0; i < e_n; i++) if (idx < 0 && e_dict[i] == eng_data_in) idx = i;
        if (idx < 0) begin
          idx = e_n;
          if (stub_mode == 0) begin
            e_dict[e_n] = eng_data_in;
            e_n++;
          end
        end
        c = CW'(idx);
        r = 2'b01;
      end else if (int'(eng_compressed_in) < e_n) begin
        d = e_dict[eng_compressed_in];
        r = 2'b10;
      end else begin
        r = 2'b11;
      end
      if (stub_mode == 1) r = 2'b00;
      else if (stub_mode == 2) r = stub_rsp;
      if (eng_dly == 0) begin
        eng_response         <= r;
        eng_compressed_out   <= c;
        eng_decompressed_out <= d;
      end else begin
        p_pend = 1'b1;
        p_left = eng_dly;
        p_rsp  = r;
        p_data = d;
        p_code = c;
      end
    end else if (p_pend) begin
      p_left--;
      if (p_left == 0) begin
        eng_response         <= p_rsp;
        eng_compressed_out   <= p_code;
        eng_decompressed_out <= p_data;
        p_pend = 1'b0;
      end
    end
  end

  // ---------------- Scoreboard ----------------
  int pass_cnt = 0;
  int tot_cnt = 0;
  int ok_exp = 0;
  int err_exp = 0;
  logic [DW-1:0] ref_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: engine dictionary semantics plus initiator status/timeout rules.
  task automatic model(input logic op, input logic [DW-1:0] data, input logic [CW-1:0] code,
                       input int dly, output logic [1:0] st, output logic [DW-1:0] ed,
                       output logic [CW-1:0] ec, output int elat);
    int  idx;
    logic eng_err;
    ed = '0;
    ec = '0;
    eng_err = 1'b0;
    if (!op) begin
      idx = -1;
      foreach (ref_q[i]) if (idx < 0 && ref_q[i] == data) idx = i;
      if (idx < 0) begin
        idx = ref_q.size();
        ref_q.push_back(data);
      end
      ec = CW'(idx);
    end else if (int'(code) < ref_q.size()) begin
      ed = ref_q[code];
    end else begin
      eng_err = 1'b1;
    end
    if (dly >= int'(TO)) begin
      st   = 2'b10;
      elat = 1 + int'(TO);
    end else begin
      st   = eng_err ? 2'b01 : 2'b00;
      elat = 2 + dly;
    end
  endtask

  // Drive one request; hold rsp_ready low for rdy_dly cycles while offering another request.
  task automatic do_req(input logic op, input logic [DW-1:0] data, input logic [CW-1:0] code,
                        input int rdy_dly, output logic [1:0] st, output logic [DW-1:0] rd,
                        output logic [CW-1:0] rc, output int lat, output logic cmd_ok);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_code  = code;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) chk("req_accept", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cmd_ok = (eng_command == (op ? 2'b10 : 2'b01)) && (eng_data_in == data) &&
             (eng_compressed_in == code);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (eng_command != 2'b00 || eng_data_in != data || eng_compressed_in != code) cmd_ok = 1'b0;
    end while (!bus.rsp_valid && lat < 40);
    st = bus.rsp_status;
    rd = bus.rsp_data;
    rc = bus.rsp_code;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      chk("bp_rsp_valid", DW'(bus.rsp_valid), 1);
      chk("bp_req_ready", DW'(bus.req_ready), 0);
      chk("bp_status", DW'(bus.rsp_status), DW'(st));
      chk("bp_data", bus.rsp_data, rd);
      chk("bp_code", DW'(bus.rsp_code), DW'(rc));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] st, input logic [DW-1:0] rd,
                           input logic [CW-1:0] rc, input int lat, input logic cmd_ok,
                           input logic [1:0] est, input logic [DW-1:0] ed,
                           input logic [CW-1:0] ec, input logic cd, input int elat);
    chk({tag, "_status"}, DW'(st), DW'(est));
    chk({tag, "_latency"}, DW'(lat), DW'(elat));
    chk({tag, "_eng_pins"}, DW'(cmd_ok), 1);
    if (cd) begin
      chk({tag, "_data"}, rd, ed);
      chk({tag, "_code"}, DW'(rc), DW'(ec));
    end
    if (est == 2'b00) ok_exp = (ok_exp < CMAX) ? ok_exp + 1 : CMAX;
    else err_exp = (err_exp < CMAX) ? err_exp + 1 : CMAX;
    chk({tag, "_ok_count"}, DW'(ok_count), DW'(ok_exp));
    chk({tag, "_err_count"}, DW'(err_count), DW'(err_exp));
    chk({tag, "_idle"}, DW'(bus.req_ready), 1);
  endtask

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    logic [CW-1:0] code;
    int            mode;
    logic [1:0]    srsp;
    int            rdy;
    logic [1:0]    est;
    logic [DW-1:0] edata;
    logic [CW-1:0] ecode;
    logic          cd;
    int            elat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [1:0]    st, est;
    logic [DW-1:0] rd, ed, pool[12];
    logic [CW-1:0] rc, ec, code;
    logic          cmd_ok, op;
    int            lat, elat, dly;

    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_data  = '0;
    bus.req_code  = '0;
    bus.rsp_ready = 1'b0;

    //           op    data        code   mode srsp  rdy est    edata      ecode  cd  lat
    tbl[0] = '{1'b0, 80'h1234, 8'h00, 0, 2'b00, 0, 2'b00, 80'h0,    8'h00, 1'b1, 2};
    tbl[1] = '{1'b0, 80'hA5,   8'h00, 0, 2'b00, 0, 2'b00, 80'h0,    8'h01, 1'b1, 2};
    tbl[2] = '{1'b1, 80'h0,    8'h01, 0, 2'b00, 5, 2'b00, 80'hA5,   8'h00, 1'b1, 2};
    tbl[3] = '{1'b1, 80'h0,    8'hF0, 0, 2'b00, 0, 2'b01, 80'h0,    8'h00, 1'b0, 2};
    tbl[4] = '{1'b0, 80'h77,   8'h00, 1, 2'b00, 0, 2'b10, 80'h0,    8'h00, 1'b0, 9};
    tbl[5] = '{1'b0, 80'h88,   8'h00, 2, 2'b10, 2, 2'b11, 80'h0,    8'h00, 1'b0, 2};
    tbl[6] = '{1'b1, 80'h0,    8'h00, 2, 2'b01, 0, 2'b11, 80'h0,    8'h00, 1'b0, 2};
    tbl[7] = '{1'b1, 80'h0,    8'h00, 0, 2'b00, 1, 2'b00, 80'h1234, 8'h00, 1'b1, 2};
    tbl[8] = '{1'b0, 80'h99,   8'h00, 2, 2'b11, 0, 2'b01, 80'h0,    8'h00, 1'b0, 2};

    // Reset values while reset is held.
    #12;
    chk("rst_req_ready", DW'(bus.req_ready), 1);
    chk("rst_rsp_valid", DW'(bus.rsp_valid), 0);
    chk("rst_status", DW'(bus.rsp_status), 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_code", DW'(bus.rsp_code), 0);
    chk("rst_eng_cmd", DW'(eng_command), 0);
    chk("rst_eng_data", eng_data_in, 0);
    chk("rst_eng_code", DW'(eng_compressed_in), 0);
    chk("rst_ok_count", DW'(ok_count), 0);
    chk("rst_err_count", DW'(err_count), 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      stub_mode = tbl[i].mode;
      stub_rsp  = tbl[i].srsp;
      eng_dly   = 0;
      if (tbl[i].mode == 0) model(tbl[i].op, tbl[i].data, tbl[i].code, 0, st, ed, ec, elat);
      do_req(tbl[i].op, tbl[i].data, tbl[i].code, tbl[i].rdy, st, rd, rc, lat, cmd_ok);
      check_rsp($sformatf("vec%0d", i), st, rd, rc, lat, cmd_ok, tbl[i].est, tbl[i].edata,
                tbl[i].ecode, tbl[i].cd, tbl[i].elat);
      repeat (3) @(negedge clk);
    end

    // Reset asserted while waiting on a silent engine.
    stub_mode = 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_data  = 80'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_req_ready", DW'(bus.req_ready), 1);
    chk("mrst_rsp_valid", DW'(bus.rsp_valid), 0);
    chk("mrst_eng_cmd", DW'(eng_command), 0);
    chk("mrst_ok_count", DW'(ok_count), 0);
    chk("mrst_err_count", DW'(err_count), 0);
    @(negedge clk);
    reset = 1'b1;
    ok_exp  = 0;
    err_exp = 0;
    stub_mode = 0;
    // Engine dictionary survives the initiator reset.
    model(1'b0, 80'hA5, 8'h00, 0, est, ed, ec, elat);
    do_req(1'b0, 80'hA5, 8'h00, 0, st, rd, rc, lat, cmd_ok);
    check_rsp("post_rst", st, rd, rc, lat, cmd_ok, est, ed, ec, 1'b1, elat);
    repeat (3) @(negedge clk);

    // Unexpected-response storm drives err_count into saturation.
    stub_mode = 2;
    stub_rsp  = 2'b10;
    for (int i = 0; i < 18; i++) begin
      do_req(1'b0, 80'hBEEF, 8'h00, 0, st, rd, rc, lat, cmd_ok);
      check_rsp("sat", st, rd, rc, lat, cmd_ok, 2'b11, '0, '0, 1'b0, 2);
      repeat (2) @(negedge clk);
    end
    chk("sat_final", DW'(err_count), DW'(CMAX));

    // Random traffic against the reference model.
    stub_mode = 0;
    for (int i = 0; i < 12; i++) pool[i] = {$urandom(), $urandom(), 16'(i)};
    for (int n = 0; n < 40; n++) begin
      op   = 1'($urandom_range(0, 1));
      rd   = pool[$urandom_range(0, 11)];
      code = CW'($urandom_range(0, ref_q.size() + 1));
      dly  = $urandom_range(0, 9);
      eng_dly = dly;
      model(op, rd, code, dly, est, ed, ec, elat);
      do_req(op, rd, code, $urandom_range(0, 3), st, rd, rc, lat, cmd_ok);
      check_rsp($sformatf("rnd%0d", n), st, rd, rc, lat, cmd_ok, est, ed, ec, est == 2'b00,
                elat);
      repeat (4) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/compression_initiator.md
Name: compression_initiator

Overview:
- Host-side initiator for the dictionary compression engine. Takes compress/decompress requests on a valid/ready stream and drives the engine's command/data_in/compressed_in pins.
- Captures the engine's compressed_out/decompressed_out/response and returns one result per request on a valid/ready response stream, with status and counters.
- Sits between the test/host traffic source and the engine instance; one request is in flight at a time.

Parameters:
- DATA_W, 80, width of an uncompressed word
- CODE_W, 8, width of a compressed code
- TIMEOUT_CYCLES, 8, maximum WAIT cycles with engine response 00 before the request is aborted (valid range 1..255)
- CNT_W, 16, width of the saturating status counters

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  initiator can accept a request
- req_op  in  1  0=compress, 1=decompress
- req_data  in  DATA_W  word to compress
- req_code  in  CODE_W  code to decompress
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_status  out  2  00 ok, 01 engine error, 10 timeout, 11 unexpected response
- rsp_data  out  DATA_W  decompressed word (0 for compress ops)
- rsp_code  out  CODE_W  compressed code (0 for decompress ops)
- eng_command  out  2  to engine command
- eng_data_in  out  DATA_W  to engine data_in
- eng_compressed_in  out  CODE_W  to engine compressed_in
- eng_compressed_out  in  CODE_W  from engine
- eng_decompressed_out  in  DATA_W  from engine
- eng_response  in  2  from engine
- ok_count  out  CNT_W  saturating count of status-00 results
- err_count  out  CNT_W  saturating count of non-00 results

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, eng_command=00, eng_data_in=0, eng_compressed_in=0.
  - rsp_valid=0, rsp_status=0, rsp_data=0, rsp_code=0, counters=0, wait counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational in IDLE only).
  - On req_valid: latch op; drive eng_data_in=req_data, eng_compressed_in=req_code, eng_command=01 (op 0) or 10 (op 1); go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Command held on the engine pins; the engine samples it at the end of this cycle.
  - Next state WAIT; eng_command returns to 00 on entry to WAIT.
  - eng_data_in and eng_compressed_in stay held until IDLE.
- WAIT:
  - Sample eng_response each cycle.
  - 00: increment wait counter; if it reaches TIMEOUT_CYCLES, status=10, go to RESP.
  - 11: status=01.
  - Matches op (01 for compress, 10 for decompress): status=00; capture eng_compressed_out into rsp_code (compress) or eng_decompressed_out into rsp_data (decompress).
  - Other nonzero value (01 on decompress, 10 on compress): status=11.
  - All non-00 cases go to RESP.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - On rsp_valid & rsp_ready: increment ok_count (status 00) or err_count (else), saturating at all-ones; clear rsp_valid; go to IDLE.
  - rsp_data/rsp_code not cleared between transactions. The unused field is forced to 0 at capture.
- Latency with a directly connected engine: accept edge E0 → rsp_valid high after edge E2 (2 edges). Back-to-back throughput with rsp_ready=1 is one request per 4 cycles.
- eng_command is never 11; it is 00 in every state except ISSUE.
- Wait counter clears on entry to WAIT.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight result is discarded and counters are cleared. The engine's own reset is separate; its dictionary is unaffected.
- req_valid while not IDLE is ignored (req_ready=0). rsp_ready outside RESP is ignored.

Decomposition:
- Shared package compression_pkg:
  - cmd_t enum: CMD_NOP=2'b00, CMD_COMPRESS=2'b01, CMD_DECOMPRESS=2'b10, CMD_INVALID=2'b11.
  - rsp_t with the same encodings: RSP_IDLE/RSP_COMP/RSP_DECOMP/RSP_ERR.
  - status_t enum: ST_OK, ST_ENG_ERR, ST_TIMEOUT, ST_UNEXP.
  - init_state_t enum for IDLE/ISSUE/WAIT/RESP.
  - DATA_W/CODE_W default constants.
- One sub-module, sat_counter (parameter WIDTH; inc, clear), instantiated twice for ok_count and err_count.

Test Plan:
- Compress after engine reset: req_op=0, req_data=80'h1234 → ISSUE cycle has eng_command=01 and eng_data_in=80'h1234. Two edges after accept: rsp_valid=1, rsp_status=00, rsp_code=8'h00; ok_count=1.
- Round trip: compress 80'hA5 (code 1 after 80'h1234), then decompress req_code=8'h01 → rsp_status=00, rsp_data=80'hA5, rsp_code=0; ok_count=3.
- Engine error: decompress req_code=8'hF0 with 2 entries in dictionary → engine returns 11; rsp_status=01, err_count=1.
- Timeout: engine stubbed to hold response 00, TIMEOUT_CYCLES=8 → rsp_status=10 after 8 WAIT cycles; eng_command stays 00 throughout WAIT.
- Backpressure and mid-operation reset:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_* stable, req_ready=0, a second req_valid is not accepted.
  - Assert reset during WAIT → next cycle state=IDLE, rsp_valid=0, counters=0, eng_command=00.
- Unexpected response: stub returns 10 to a compress command → rsp_status=11, err_count increments; the counter saturates at 16'hFFFF after forced preload.
